// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Start/busy/done handshake; divide by zero finishes in a single cycle.
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH:0]   rem, rem_nxt;
    logic [WIDTH-1:0] dvd, dvd_nxt;
    logic [WIDTH-1:0] dvs;
    logic [CW-1:0]    cnt;
    logic [WIDTH+1:0] sh, diff;
    logic             accept;
    logic             last;

    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == '0);
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    // One extra bit above the shifted remainder carries the trial sign
    assign sh   = {rem, dvd[WIDTH-1]};
    assign diff = sh - {2'b00, dvs};

    always_comb begin
        rem_nxt = sh[WIDTH:0];
        dvd_nxt = {dvd[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH+1]) begin
            rem_nxt    = diff[WIDTH:0];
            dvd_nxt[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (b == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (cnt == '0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt = (b == '0) ? DONE : RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem         <= '0;
            dvd         <= '0;
            dvs         <= '0;
            cnt         <= '0;
            q           <= '0;
            r           <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            rem         <= '0;
            dvd         <= a;
            dvs         <= b;
            cnt         <= CNT_LAST;
            div_by_zero <= (b == '0);
            if (b == '0) begin
                q <= '1;
                r <= a;
            end
        end else if (state == RUN) begin
            rem <= rem_nxt;
            dvd <= dvd_nxt;
            cnt <= cnt - CW'(1);
            if (last) begin
                q <= dvd_nxt;
                r <= rem_nxt[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and sweep checks for seq_restoring_divider at WIDTH=4.
// Inputs change at negedge / posedge+1; outputs are sampled at negedge.
module tb_seq_restoring_divider;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .q           (q),
        .r           (r),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Caller sits at a negedge with the divider able to accept.
    // Returns at the negedge of the done cycle.
    task automatic run_op(input string tag, input int av, input int bv,
                          input int eq, input int er, input int edz);
        int lat;
        int nbusy;
        int elat;
        lat   = 0;
        nbusy = 0;
        elat  = (edz != 0) ? 1 : W + 1;
        start = 1'b1;
        a     = W'(av);
        b     = W'(bv);
        @(posedge clk);
        #1 start = 1'b0;
        a = ~a;
        b = ~b;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            lat = i;
            if (done) break;
            if (busy) nbusy++;
        end
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_busy"}, nbusy, elat - 1);
        chk({tag, "_busy_done"}, int'(busy), 0);
        chk({tag, "_q"}, int'(q), eq);
        chk({tag, "_r"}, int'(r), er);
        chk({tag, "_dbz"}, int'(div_by_zero), edz);
    endtask

    initial begin
        int ndone;
        int first;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;

        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_q", int'(q), 0);
        chk("rst_r", int'(r), 0);
        chk("rst_dbz", int'(div_by_zero), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("t1", 13, 4, 3, 1, 0);
        @(negedge clk);
        chk("t1_done_once", int'(done), 0);
        chk("t1_hold_q", int'(q), 3);

        run_op("t2a", 3, 7, 0, 3, 0);
        @(negedge clk);
        run_op("t2b", 15, 1, 15, 0, 0);
        @(negedge clk);
        run_op("t2c", 15, 15, 1, 0, 0);
        @(negedge clk);

        run_op("t3a", 5, 0, 15, 5, 1);
        @(negedge clk);
        chk("t3_dbz_hold", int'(div_by_zero), 1);
        run_op("t3b", 8, 2, 4, 0, 0);
        @(negedge clk);

        // start pulsed mid-run must be ignored
        start = 1'b1;
        a     = 4'd13;
        b     = 4'd4;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        a     = 4'd9;
        b     = 4'd9;
        @(posedge clk);
        #1 start = 1'b0;
        ndone = 0;
        first = 0;
        for (int i = 3; i <= 12; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (first == 0) first = i;
            end
        end
        chk("t4_ndone", ndone, 1);
        chk("t4_lat", first, W + 1);
        chk("t4_q", int'(q), 3);
        chk("t4_r", int'(r), 1);

        // async reset in the second run cycle
        start = 1'b1;
        a     = 4'd13;
        b     = 4'd4;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_busy", int'(busy), 0);
        chk("t5_done", int'(done), 0);
        chk("t5_q", int'(q), 0);
        chk("t5_r", int'(r), 0);
        ndone = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("t5_no_done", ndone, 0);
        rst_n = 1'b1;
        run_op("t5b", 14, 3, 4, 2, 0);

        // back-to-back: start held in the done cycle
        @(negedge clk);
        run_op("t6a", 13, 4, 3, 1, 0);
        run_op("t6b", 10, 3, 3, 1, 0);
        @(negedge clk);

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                if (y == 0) begin
                    run_op("sw0", x, 0, 15, x, 1);
                end else begin
                    run_op("sw", x, y, x / y, x % y, 0);
                    chk("sw_ident", int'(q) * y + int'(r), x);
                    chk("sw_rlt", int'(int'(r) < y), 1);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
